// File: rtl/ov5640_init_seq.sv
// OV5640 register-init sequencer: walks a fixed ROM table, substitutes runtime fields, drives SCCB writes.
// Optional NACK retry enabled by defining OV5640_SEQ_RETRY_EN.
module ov5640_init_seq #(
   parameter int unsigned TABLE_LEN       = 86,
   parameter int unsigned ADDR_WIDTH      = 8,
   parameter logic [23:0] PWR_WAIT_CYCLES = 24'd1_200_000,
   parameter logic [23:0] RST_WAIT_CYCLES = 24'd120_000,
   parameter int unsigned MAX_RETRY       = 3,
   parameter logic        IMAGE_FLIP_EN   = 1'b0,
   parameter logic        IMAGE_MIRROR_EN = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mode_sel,
   input  logic [11:0]           img_width,
   input  logic [11:0]           img_height,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [15:0]           wr_reg_addr,
   output logic [7:0]            wr_reg_data,
   input  logic                  wr_done,
   input  logic                  wr_nack,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] progress
);

   typedef enum logic [2:0] {
      IDLE, PWR_WAIT, FETCH, ISSUE, WAIT_RESP, RST_WAIT, DONE, ERROR
   } state_e;

   state_e                state_q, state_d;
   logic [23:0]           cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] index_q, index_d;
   logic [23:0]           rom_q, rom_d;
   logic                  fetch_ph_q, fetch_ph_d;
   logic [15:0]           wr_addr_q, wr_addr_d;
   logic [7:0]            wr_data_q, wr_data_d;
   logic                  mode_q, mode_d;
   logic [11:0]           width_q, width_d;
   logic [11:0]           height_q, height_d;
   logic [7:0]            sub_data;
   logic                  advance;
   logic                  last_entry;
`ifdef OV5640_SEQ_RETRY_EN
   localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RETRY_W-1:0]    retry_q, retry_d;
`endif

   always_comb begin
      rom_d = '0;
      case (int'(index_q))
         0:  rom_d = 24'h3008_82;  1:  rom_d = 24'h3008_42;  2:  rom_d = 24'h3103_03;  3:  rom_d = 24'h3017_ff;
         4:  rom_d = 24'h3018_ff;  5:  rom_d = 24'h3034_1a;  6:  rom_d = 24'h3035_21;  7:  rom_d = 24'h3036_46;
         8:  rom_d = 24'h3037_13;  9:  rom_d = 24'h3108_01;  10: rom_d = 24'h3820_40;  11: rom_d = 24'h3821_07;
         12: rom_d = 24'h3808_0a;  13: rom_d = 24'h3809_20;  14: rom_d = 24'h380a_07;  15: rom_d = 24'h380b_98;
         16: rom_d = 24'h4300_f8;  17: rom_d = 24'h501f_00;  18: rom_d = 24'h3630_36;  19: rom_d = 24'h3631_0e;
         20: rom_d = 24'h3632_e2;  21: rom_d = 24'h3633_12;  22: rom_d = 24'h3621_e0;  23: rom_d = 24'h3704_a0;
         24: rom_d = 24'h3703_5a;  25: rom_d = 24'h3715_78;  26: rom_d = 24'h3717_01;  27: rom_d = 24'h370b_60;
         28: rom_d = 24'h3705_1a;  29: rom_d = 24'h3905_02;  30: rom_d = 24'h3906_10;  31: rom_d = 24'h3901_0a;
         32: rom_d = 24'h3731_12;  33: rom_d = 24'h3600_08;  34: rom_d = 24'h3601_33;  35: rom_d = 24'h302d_60;
         36: rom_d = 24'h3620_52;  37: rom_d = 24'h371b_20;  38: rom_d = 24'h471c_50;  39: rom_d = 24'h3a13_43;
         40: rom_d = 24'h3a18_00;  41: rom_d = 24'h3a19_f8;  42: rom_d = 24'h3635_13;  43: rom_d = 24'h3636_03;
         44: rom_d = 24'h3634_40;  45: rom_d = 24'h3622_01;  46: rom_d = 24'h3c01_34;  47: rom_d = 24'h3c04_28;
         48: rom_d = 24'h3c05_98;  49: rom_d = 24'h3c06_00;  50: rom_d = 24'h3c07_08;  51: rom_d = 24'h3c08_00;
         52: rom_d = 24'h3c09_1c;  53: rom_d = 24'h3c0a_9c;  54: rom_d = 24'h3c0b_40;  55: rom_d = 24'h3800_00;
         56: rom_d = 24'h3801_00;  57: rom_d = 24'h3802_00;  58: rom_d = 24'h3803_04;  59: rom_d = 24'h3804_0a;
         60: rom_d = 24'h3805_3f;  61: rom_d = 24'h3806_07;  62: rom_d = 24'h3807_9b;  63: rom_d = 24'h380c_07;
         64: rom_d = 24'h380d_68;  65: rom_d = 24'h380e_03;  66: rom_d = 24'h380f_d8;  67: rom_d = 24'h3810_00;
         68: rom_d = 24'h3811_10;  69: rom_d = 24'h3812_00;  70: rom_d = 24'h3813_06;  71: rom_d = 24'h3814_31;
         72: rom_d = 24'h3815_31;  73: rom_d = 24'h3618_00;  74: rom_d = 24'h3612_29;  75: rom_d = 24'h3708_64;
         76: rom_d = 24'h3709_52;  77: rom_d = 24'h370c_03;  78: rom_d = 24'h4001_02;  79: rom_d = 24'h4004_02;
         80: rom_d = 24'h3000_00;  81: rom_d = 24'h3002_1c;  82: rom_d = 24'h3004_ff;  83: rom_d = 24'h3006_c3;
         84: rom_d = 24'h4713_03;  85: rom_d = 24'h3008_02;
         default: rom_d = '0;
      endcase
   end

   // Runtime fields replace the ROM data on the second FETCH cycle.
   always_comb begin
      sub_data = rom_q[7:0];
      case (rom_q[23:8])
         16'h3808: sub_data = {4'h0, width_q[11:8]};
         16'h3809: sub_data = width_q[7:0];
         16'h380a: sub_data = {4'h0, height_q[11:8]};
         16'h380b: sub_data = height_q[7:0];
         16'h4300: sub_data = mode_q ? 8'h61 : 8'h03;
         16'h501f: sub_data = mode_q ? 8'h01 : 8'h03;
         16'h3820: sub_data = IMAGE_FLIP_EN ? 8'h47 : 8'h40;
         16'h3821: sub_data = IMAGE_MIRROR_EN ? 8'h00 : 8'h07;
         default:  sub_data = rom_q[7:0];
      endcase
   end

   assign last_entry = (index_q == ADDR_WIDTH'(TABLE_LEN - 1));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      index_d    = index_q;
      fetch_ph_d = fetch_ph_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      mode_d     = mode_q;
      width_d    = width_q;
      height_d   = height_q;
      advance    = 1'b0;
`ifdef OV5640_SEQ_RETRY_EN
      retry_d    = retry_q;
`endif
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d  = PWR_WAIT;
               cnt_d    = '0;
               index_d  = '0;
               mode_d   = mode_sel;
               width_d  = img_width;
               height_d = img_height;
`ifdef OV5640_SEQ_RETRY_EN
               retry_d  = '0;
`endif
            end
         end
         PWR_WAIT: begin
            if (cnt_q == PWR_WAIT_CYCLES - 24'd1) state_d = FETCH;
            else                                  cnt_d   = cnt_q + 24'd1;
         end
         FETCH: begin
            if (!fetch_ph_q) begin
               fetch_ph_d = 1'b1;
            end else begin
               fetch_ph_d = 1'b0;
               wr_addr_d  = rom_q[23:8];
               wr_data_d  = sub_data;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (wr_ready) state_d = WAIT_RESP;
         end
         WAIT_RESP: begin
            if (wr_nack) begin
`ifdef OV5640_SEQ_RETRY_EN
               if (retry_q < RETRY_W'(MAX_RETRY)) begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = FETCH;
               end else begin
                  state_d = ERROR;
               end
`else
               state_d = ERROR;
`endif
            end else if (wr_done) begin
               if (wr_addr_q == 16'h3008 && wr_data_q[7]) begin
                  state_d = RST_WAIT;
                  cnt_d   = '0;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         RST_WAIT: begin
            if (cnt_q == RST_WAIT_CYCLES - 24'd1) advance = 1'b1;
            else                                  cnt_d   = cnt_q + 24'd1;
         end
         default: state_d = IDLE;
      endcase
      if (advance) begin
         if (last_entry) begin
            state_d = DONE;
         end else begin
            state_d = FETCH;
            index_d = index_q + ADDR_WIDTH'(1);
`ifdef OV5640_SEQ_RETRY_EN
            retry_d = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         index_q    <= '0;
         rom_q      <= '0;
         fetch_ph_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         mode_q     <= 1'b0;
         width_q    <= '0;
         height_q   <= '0;
`ifdef OV5640_SEQ_RETRY_EN
         retry_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         index_q    <= index_d;
         rom_q      <= rom_d;
         fetch_ph_q <= fetch_ph_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         mode_q     <= mode_d;
         width_q    <= width_d;
         height_q   <= height_d;
`ifdef OV5640_SEQ_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

   assign wr_valid    = (state_q == ISSUE);
   assign wr_reg_addr = wr_addr_q;
   assign wr_reg_data = wr_data_q;
   assign busy        = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
   assign done        = (state_q == DONE);
   assign error       = (state_q == ERROR);
   assign progress    = index_q;

endmodule

// File: tb/tb_ov5640_init_seq.sv
// Randomized self-checking bench for ov5640_init_seq against a table-level reference model.
module tb_ov5640_init_seq;
   localparam int unsigned TL = 20;
   localparam int unsigned AW = 8;
   localparam int unsigned MR = 3;
`ifdef OV5640_SEQ_RETRY_EN
   localparam int ALLOWED = MR;
`else
   localparam int ALLOWED = 0;
`endif
   localparam logic [23:0] REF_TAB [TL] = '{
      24'h3008_82, 24'h3008_42, 24'h3103_03, 24'h3017_ff, 24'h3018_ff,
      24'h3034_1a, 24'h3035_21, 24'h3036_46, 24'h3037_13, 24'h3108_01,
      24'h3820_40, 24'h3821_07, 24'h3808_0a, 24'h3809_20, 24'h380a_07,
      24'h380b_98, 24'h4300_f8, 24'h501f_00, 24'h3630_36, 24'h3631_0e};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, start, mode_sel, wr_ready, wr_done, wr_nack;
   logic [11:0]   img_width, img_height;
   logic          wr_valid, busy, done, error;
   logic [15:0]   wr_reg_addr;
   logic [7:0]    wr_reg_data;
   logic [AW-1:0] progress;

   ov5640_init_seq #(.TABLE_LEN(TL), .ADDR_WIDTH(AW), .PWR_WAIT_CYCLES(24'd4),
                     .RST_WAIT_CYCLES(24'd10), .MAX_RETRY(MR)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode_sel(mode_sel),
      .img_width(img_width), .img_height(img_height), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .wr_reg_addr(wr_reg_addr), .wr_reg_data(wr_reg_data),
      .wr_done(wr_done), .wr_nack(wr_nack), .busy(busy), .done(done),
      .error(error), .progress(progress));

   // Single-entry instance with an always-ready, always-ACK responder.
   logic          one_start, one_valid, one_ready, one_wdone, one_busy, one_done, one_error;
   logic [15:0]   one_addr;
   logic [7:0]    one_data;
   logic [AW-1:0] one_prog;
   int unsigned   one_cnt = 0;
   logic [23:0]   one_seen = '0;

   ov5640_init_seq #(.TABLE_LEN(1), .ADDR_WIDTH(AW), .PWR_WAIT_CYCLES(24'd2),
                     .RST_WAIT_CYCLES(24'd3), .MAX_RETRY(MR)) u_one (
      .clk(clk), .rst_n(rst_n), .start(one_start), .mode_sel(1'b0),
      .img_width(12'd0), .img_height(12'd0), .wr_valid(one_valid),
      .wr_ready(one_ready), .wr_reg_addr(one_addr), .wr_reg_data(one_data),
      .wr_done(one_wdone), .wr_nack(1'b0), .busy(one_busy), .done(one_done),
      .error(one_error), .progress(one_prog));

   always @(posedge clk) begin
      one_wdone <= one_valid & one_ready;
      if (one_valid) begin
         one_cnt  <= one_cnt + 1;
         one_seen <= {one_addr, one_data};
      end
   end

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] expect_entry(input int idx, input logic m,
                                                input logic [11:0] w, input logic [11:0] h);
      logic [15:0] a;
      logic [7:0]  d;
      a = REF_TAB[idx][23:8];
      d = REF_TAB[idx][7:0];
      case (a)
         16'h3808: d = 8'(w / 256);
         16'h3809: d = 8'(w % 256);
         16'h380a: d = 8'(h / 256);
         16'h380b: d = 8'(h % 256);
         16'h4300: d = m ? 8'h61 : 8'h03;
         16'h501f: d = m ? 8'h01 : 8'h03;
         16'h3820: d = 8'h40;
         16'h3821: d = 8'h07;
         default: ;
      endcase
      return {a, d};
   endfunction

   // One full run: nidx/ncnt inject NACKs, both adds wr_done to them, rdly<0 randomizes ready delay.
   task automatic run(input logic m, input logic [11:0] w, input logic [11:0] h,
                      input int nidx, input int ncnt, input logic both,
                      input int rdly, input int busy_start_idx);
      int          i, att, n, exp_gap, rd, cv;
      logic        fail_exp, stop, nk;
      logic [23:0] e;
      mode_sel = m; img_width = w; img_height = h; start = 1'b1;
      step();
      start = 1'b0; mode_sel = ~m; img_width = 12'($urandom); img_height = 12'($urandom);
      check("busy_after_start", busy, 1);
      check("done_cleared", done, 0);
      check("error_cleared", error, 0);
      i = 0; att = 0; exp_gap = 6; fail_exp = 1'b0; stop = 1'b0;
      while (!stop) begin
         n = 0;
         while (!wr_valid && n < 200) begin
            step();
            n++;
         end
         check("issue_gap", n, exp_gap);
         if (!wr_valid) begin
            stop = 1'b1;
         end else begin
            e = expect_entry(i, m, w, h);
            check("wr_reg_addr", wr_reg_addr, e[23:8]);
            check("wr_reg_data", wr_reg_data, e[7:0]);
            check("progress_run", progress, i);
            rd = (rdly < 0) ? int'($urandom_range(0, 3)) : rdly;
            for (int k = 0; k < rd; k++) begin
               step();
               check("valid_hold", {wr_valid, wr_reg_addr, wr_reg_data}, {1'b1, e});
            end
            wr_ready = 1'b1;
            step();
            wr_ready = 1'b0;
            check("valid_drop", wr_valid, 0);
            if (i == busy_start_idx) begin
               start = 1'b1; mode_sel = ~m;
               step();
               start = 1'b0;
            end
            rd = int'($urandom_range(0, 2));
            for (int k = 0; k < rd; k++) step();
            nk = (i == nidx) && (att < ncnt);
            wr_done = !nk || both;
            wr_nack = nk;
            step();
            wr_done = 1'b0; wr_nack = 1'b0;
            if (nk) begin
               att++;
               if (att > ALLOWED) begin
                  fail_exp = 1'b1;
                  stop = 1'b1;
               end else begin
                  exp_gap = 2;
               end
            end else begin
               exp_gap = (e[23:8] == 16'h3008 && e[7]) ? 12 : 2;
               att = 0;
               i++;
               if (i == TL) stop = 1'b1;
            end
         end
      end
      for (int k = 0; k < 15; k++) step();
      check("done_final", done, !fail_exp);
      check("error_final", error, fail_exp);
      check("busy_final", busy, 0);
      check("progress_final", progress, fail_exp ? nidx : TL - 1);
      cv = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (wr_valid) cv++;
      end
      check("no_extra_write", cv, 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; mode_sel = 1'b0; img_width = '0; img_height = '0;
      wr_ready = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
      one_start = 1'b0; one_ready = 1'b1;
      repeat (3) step();
      check("rst_wr_valid", wr_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_progress", progress, 0);
      check("rst_wr_addr", {wr_reg_addr, wr_reg_data}, 0);
      rst_n = 1'b1;
      step();

      one_start = 1'b1;
      step();
      one_start = 1'b0;
      n = 0;
      while (!one_done && n < 60) begin
         step();
         n++;
      end
      check("one_done", one_done, 1);
      check("one_writes", one_cnt, 1);
      check("one_entry", one_seen, 24'h3008_82);
      check("one_busy_err", {one_busy, one_error, one_prog}, 0);

      run(1'b0, 12'($urandom), 12'($urandom), -1, 0, 1'b0, 2, -1);
      run(1'b1, 12'd1280, 12'd720, -1, 0, 1'b0, -1, 2);
`ifdef OV5640_SEQ_RETRY_EN
      run(1'($urandom), 12'($urandom), 12'($urandom), 5, 2, 1'b0, -1, -1);
      run(1'($urandom), 12'($urandom), 12'($urandom), 5, 4, 1'b0, -1, -1);
`else
      run(1'($urandom), 12'($urandom), 12'($urandom), 5, 1, 1'b0, -1, -1);
`endif
      run(1'($urandom), 12'($urandom), 12'($urandom), 3, 1, 1'b1, -1, -1);

      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!wr_valid && n < 50) begin
         step();
         n++;
      end
      check("pre_reset_issue", wr_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_valid", wr_valid, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_progress", progress, 0);
      step();
      rst_n = 1'b1;
      step();
      run(1'($urandom), 12'($urandom), 12'($urandom), -1, 0, 1'b0, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
